// File: rtl/conv_bias_prefetch.sv
// Conv bias-fetch stage: walks X/W rounds, reads one BM bias word per round, streams it into the bias FIFO.
// Optional CONV_BIAS_STALL_CNT_EN adds a saturating stall_cnt output counting prog_full stalls.
module conv_bias_prefetch #(
    parameter int BM_AW     = 9,
    parameter int BM_DW     = 64,
    parameter int BM_RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_pulse,
    input  logic [BM_AW-1:0] B_addr,
    input  logic [15:0]      n_X_rnd_minus_1,
    input  logic [15:0]      n_W_rnd_minus_1,
    output logic             busy,
    output logic             done_pulse,
    output logic             bm_rd_en,
    output logic [BM_AW-1:0] bm_rd_addr,
    input  logic [BM_DW-1:0] bm_dout,
    input  logic             bm_dout_vld,
    output logic             fifo_wr_en,
    output logic [BM_DW-1:0] fifo_din,
`ifdef CONV_BIAS_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    input  logic             fifo_prog_full
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BM_AW-1:0] r_base;
    logic [15:0]      r_nx;
    logic [15:0]      r_nw;
    logic [15:0]      r_x_cnt;
    logic [15:0]      r_w_cnt;
    logic [3:0]       r_outst;
    logic [3:0]       r_flush;
    logic             r_wr_en;
    logic [BM_DW-1:0] r_din;

    logic w_accept;
    logic w_issue;
    logic w_last;
    logic w_done;
    logic w_vld;
    logic w_dec;

    assign w_accept = (r_state == IDLE) && start_pulse;
    assign w_issue  = (r_state == ISSUE) && !fifo_prog_full;
    assign w_last   = w_issue && (r_x_cnt == r_nx) && (r_w_cnt == r_nw);
    assign w_done   = (r_state == DRAIN) && (r_outst == 4'd0);
    // Reads in flight at reset return for up to BM_RD_LAT cycles afterwards; drop them.
    assign w_vld    = bm_dout_vld && (r_flush == 4'd0);
    assign w_dec    = r_wr_en && (r_outst != 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done_pulse  = 1'b0;
        bm_rd_en    = w_issue;
        bm_rd_addr  = r_base + BM_AW'(r_w_cnt);
        case (r_state)
            IDLE: begin
                if (start_pulse) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy       = !w_done;
                done_pulse = w_done;
                if (w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_nx    <= '0;
            r_nw    <= '0;
            r_x_cnt <= '0;
            r_w_cnt <= '0;
            r_outst <= '0;
            r_flush <= 4'(BM_RD_LAT);
            r_wr_en <= 1'b0;
            r_din   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= w_vld;
            r_din   <= bm_dout;
            if (r_flush != 4'd0) r_flush <= r_flush - 4'd1;

            if (w_accept) begin
                r_base  <= B_addr;
                r_nx    <= n_X_rnd_minus_1;
                r_nw    <= n_W_rnd_minus_1;
                r_x_cnt <= '0;
                r_w_cnt <= '0;
            end else if (w_issue) begin
                if (r_w_cnt == r_nw) begin
                    r_w_cnt <= '0;
                    r_x_cnt <= r_x_cnt + 16'd1;
                end else begin
                    r_w_cnt <= r_w_cnt + 16'd1;
                end
            end

            if (w_accept)
                r_outst <= '0;
            else if (w_issue && !w_dec)
                r_outst <= r_outst + 4'd1;
            else if (!w_issue && w_dec)
                r_outst <= r_outst - 4'd1;
        end
    end

    assign fifo_wr_en = r_wr_en;
    assign fifo_din   = r_din;

`ifdef CONV_BIAS_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall <= '0;
        else if (w_accept)
            r_stall <= '0;
        else if ((r_state == ISSUE) && fifo_prog_full && (r_stall != '1))
            r_stall <= r_stall + 32'd1;
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_conv_bias_prefetch.sv
// Directed self-checking bench for conv_bias_prefetch with a latency-2 BM model.
module tb_conv_bias_prefetch;

    localparam int BM_AW     = 9;
    localparam int BM_DW     = 64;
    localparam int BM_RD_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_pulse;
    logic [BM_AW-1:0] B_addr;
    logic [15:0]      n_X_rnd_minus_1;
    logic [15:0]      n_W_rnd_minus_1;
    logic             busy;
    logic             done_pulse;
    logic             bm_rd_en;
    logic [BM_AW-1:0] bm_rd_addr;
    logic [BM_DW-1:0] bm_dout;
    logic             bm_dout_vld;
    logic             fifo_wr_en;
    logic [BM_DW-1:0] fifo_din;
    logic             fifo_prog_full;
`ifdef CONV_BIAS_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    conv_bias_prefetch #(
        .BM_AW     (BM_AW),
        .BM_DW     (BM_DW),
        .BM_RD_LAT (BM_RD_LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_pulse     (start_pulse),
        .B_addr          (B_addr),
        .n_X_rnd_minus_1 (n_X_rnd_minus_1),
        .n_W_rnd_minus_1 (n_W_rnd_minus_1),
        .busy            (busy),
        .done_pulse      (done_pulse),
        .bm_rd_en        (bm_rd_en),
        .bm_rd_addr      (bm_rd_addr),
        .bm_dout         (bm_dout),
        .bm_dout_vld     (bm_dout_vld),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_din        (fifo_din),
`ifdef CONV_BIAS_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
`endif
        .fifo_prog_full  (fifo_prog_full)
    );

    function automatic logic [63:0] bm_word(input logic [8:0] a);
        return {32'hB1A5_0000 | {23'd0, a}, 32'h5EED_0000 ^ {23'd0, ~a}};
    endfunction

    // BM model: data valid two cycles after the read strobe cycle
    logic        p0_v = 1'b0;
    logic        p1_v = 1'b0;
    logic [8:0]  p0_a = '0;
    logic [63:0] p1_d = '0;
    always @(posedge clk) begin
        p0_v <= bm_rd_en;
        p0_a <= bm_rd_addr;
        p1_v <= p0_v;
        p1_d <= bm_word(p0_a);
    end
    assign bm_dout_vld = p1_v;
    assign bm_dout     = p1_d;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0]  rd_q[$];
    logic [63:0] wr_q[$];
    int unsigned n_rd_full = 0;
    int unsigned n_done = 0;
    int unsigned done_cyc = 0;
    int unsigned last_wr_cyc = 0;
    always @(negedge clk) begin
        if (bm_rd_en) begin
            rd_q.push_back(bm_rd_addr);
            if (fifo_prog_full) n_rd_full++;
        end
        if (fifo_wr_en) begin
            wr_q.push_back(fifo_din);
            last_wr_cyc = cyc;
        end
        if (done_pulse) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned start_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] b, input logic [15:0] nx, input logic [15:0] nw);
        B_addr          = b;
        n_X_rnd_minus_1 = nx;
        n_W_rnd_minus_1 = nw;
        start_pulse     = 1'b1;
        start_cyc       = cyc;
        @(posedge clk);
        #1 start_pulse = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned d0);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (n_done != d0) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int unsigned rm, input int unsigned wm,
                                input logic [8:0] b, input int unsigned nx, input int unsigned nw);
        int unsigned i;
        logic [8:0]  ea;
        check({tag, "_nrd"}, 64'(rd_q.size() - rm), 64'((nx + 1) * (nw + 1)));
        check({tag, "_nwr"}, 64'(wr_q.size() - wm), 64'((nx + 1) * (nw + 1)));
        i = 0;
        for (int unsigned x = 0; x <= nx; x++) begin
            for (int unsigned w = 0; w <= nw; w++) begin
                ea = b + 9'(w);
                if (rm + i < rd_q.size()) check({tag, "_addr"}, 64'(rd_q[rm + i]), 64'(ea));
                if (wm + i < wr_q.size()) check({tag, "_data"}, wr_q[wm + i], bm_word(ea));
                i++;
            end
        end
    endtask

    int unsigned rm, wm, dm, fm;

    initial begin
        rst_n           = 1'b0;
        start_pulse     = 1'b0;
        B_addr          = '0;
        n_X_rnd_minus_1 = '0;
        n_W_rnd_minus_1 = '0;
        fifo_prog_full  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done_pulse), 64'd0);
        check("rst_rd_en", 64'(bm_rd_en), 64'd0);
        check("rst_addr",  64'(bm_rd_addr), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_din",   fifo_din, 64'd0);
`ifdef CONV_BIAS_STALL_CNT_EN
        check("rst_stall", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Basic 2x3 walk
        rm = rd_q.size(); wm = wr_q.size(); dm = n_done;
        do_start(9'h010, 16'd1, 16'd2);
        check("t1_busy_rise", 64'(busy), 64'd1);
        wait_done("t1_done_seen", dm);
        repeat (3) @(posedge clk);
        #1;
        check_stream("t1", rm, wm, 9'h010, 1, 2);
        check("t1_ndone", 64'(n_done - dm), 64'd1);
        check("t1_done_gap", 64'(done_cyc - last_wr_cyc), 64'd1);
        check("t1_busy_low", 64'(busy), 64'd0);

        // Minimum case and latency
        rm = rd_q.size(); wm = wr_q.size(); dm = n_done;
        do_start(9'h1A0, 16'd0, 16'd0);
        wait_done("t2_done_seen", dm);
        repeat (3) @(posedge clk);
        #1;
        check_stream("t2", rm, wm, 9'h1A0, 0, 0);
        check("t2_start_to_done", 64'(done_cyc - start_cyc), 64'(BM_RD_LAT + 3));

        // Address wrap
        rm = rd_q.size(); wm = wr_q.size(); dm = n_done;
        do_start(9'h1FE, 16'd0, 16'd3);
        wait_done("t3_done_seen", dm);
        repeat (3) @(posedge clk);
        #1;
        check_stream("t3", rm, wm, 9'h1FE, 0, 3);

        // prog_full stall for 10 cycles mid-sequence
        rm = rd_q.size(); wm = wr_q.size(); dm = n_done; fm = n_rd_full;
        do_start(9'h020, 16'd2, 16'd3);
        repeat (2) @(posedge clk);
        #1 fifo_prog_full = 1'b1;
        repeat (10) @(posedge clk);
        #1 fifo_prog_full = 1'b0;
        check("t4_rd_mid", 64'(rd_q.size() - rm), 64'd2);
        wait_done("t4_done_seen", dm);
        repeat (3) @(posedge clk);
        #1;
        check("t4_rd_when_full", 64'(n_rd_full - fm), 64'd0);
        check_stream("t4", rm, wm, 9'h020, 2, 3);
`ifdef CONV_BIAS_STALL_CNT_EN
        check("t4_stall_cnt", 64'(stall_cnt), 64'd10);
`endif

        // Second start while busy is ignored
        rm = rd_q.size(); wm = wr_q.size(); dm = n_done;
        do_start(9'h030, 16'd0, 16'd4);
        @(posedge clk);
        #1;
        do_start(9'h100, 16'd3, 16'd3);
        wait_done("t5_done_seen", dm);
        repeat (20) @(posedge clk);
        #1;
        check_stream("t5", rm, wm, 9'h030, 0, 4);
        check("t5_ndone", 64'(n_done - dm), 64'd1);

        rm = rd_q.size(); wm = wr_q.size(); dm = n_done;
        do_start(9'h040, 16'd0, 16'd1);
        wait_done("t5b_done_seen", dm);
        repeat (3) @(posedge clk);
        #1;
        check_stream("t5b", rm, wm, 9'h040, 0, 1);

        // Reset after 3 of 8 reads
        rm = rd_q.size(); wm = wr_q.size(); dm = n_done;
        do_start(9'h050, 16'd1, 16'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_rd_before_rst", 64'(rd_q.size() - rm), 64'd3);
        check("t6_busy",  64'(busy), 64'd0);
        check("t6_rd_en", 64'(bm_rd_en), 64'd0);
        check("t6_wr_en", 64'(fifo_wr_en), 64'd0);
        check("t6_din",   fifo_din, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_done", 64'(n_done - dm), 64'd0);
        check("t6_no_wr", 64'(wr_q.size() - wm), 64'd0);
        check("t6_no_more_rd", 64'(rd_q.size() - rm), 64'd3);

        rm = rd_q.size(); wm = wr_q.size(); dm = n_done;
        do_start(9'h050, 16'd1, 16'd3);
        wait_done("t6b_done_seen", dm);
        repeat (3) @(posedge clk);
        #1;
        check_stream("t6b", rm, wm, 9'h050, 1, 3);
        check("t6b_ndone", 64'(n_done - dm), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
